// File: rtl/syn_ram.sv
// 16x8 simple dual-port RAM: one write port, one registered read port.
// Async active-high reset clears every word and the read register.
module syn_ram #(
  parameter int RAM_WIDTH = 8,
  parameter int RAM_DEPTH = 16,
  parameter int ADDR_SIZE = 4
) (
  input  logic                 clk,
  input  logic                 read,
  input  logic                 write,
  input  logic                 reset,
  input  logic [ADDR_SIZE-1:0] rd_addr,
  input  logic [ADDR_SIZE-1:0] wr_addr,
  input  logic [RAM_WIDTH-1:0] data_in,
  output logic [RAM_WIDTH-1:0] data_out
);

  logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];

  // Nonblocking update gives read-before-write on a shared address.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out <= '0;
      for (int i = 0; i < RAM_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (read == 1'b1) begin
        data_out <= mem[rd_addr];
      end
      if (write == 1'b1) begin
        mem[wr_addr] <= data_in;
      end
    end
  end

endmodule

// File: tb/tb_syn_ram.sv
// Directed + random bench for syn_ram.
// Scoreboard queue holds expected read data.
module tb_syn_ram;

  logic       clk = 1'b0;
  logic       read = 1'b0;
  logic       write = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] rd_addr = '0;
  logic [3:0] wr_addr = '0;
  logic [7:0] data_in = '0;
  logic [7:0] data_out;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] model [16];
  logic [7:0] exp_q [$];
  logic [7:0] hold_val = '0;

  syn_ram dut (
    .clk(clk),
    .read(read),
    .write(write),
    .reset(reset),
    .rd_addr(rd_addr),
    .wr_addr(wr_addr),
    .data_in(data_in),
    .data_out(data_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 16; i++) model[i] = '0;
    exp_q.delete();
    hold_val = '0;
  endtask

  task automatic step(input logic r, input logic w,
                      input logic [3:0] ra, input logic [3:0] wa,
                      input logic [7:0] d, input string tag);
    logic [7:0] exp;
    @(negedge clk);
    read = r; write = w;
    rd_addr = ra; wr_addr = wa; data_in = d;
    if (r) exp_q.push_back(model[ra]);
    if (w) model[wa] = d;
    @(posedge clk);
    #1;
    if (r) begin
      exp = exp_q.pop_front();
      hold_val = exp;
      check(tag, data_out, exp);
    end else begin
      check({tag, "_hold"}, data_out, hold_val);
    end
  endtask

  task automatic sweep_zero(input string tag);
    for (int a = 0; a < 16; a++) begin
      step(1'b1, 1'b0, 4'(a), 4'd0, 8'h00, tag);
      check({tag, "_zero"}, data_out, 8'h00);
    end
  endtask

  initial begin
    logic [3:0] a;
    logic [7:0] d;
    clear_model();
    #3;
    check("reset_init", data_out, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    sweep_zero("post_reset");

    step(1'b0, 1'b1, 4'd0, 4'd3, 8'hA5, "wr3");
    step(1'b0, 1'b1, 4'd0, 4'd12, 8'h3C, "wr12");
    step(1'b1, 1'b0, 4'd3, 4'd0, 8'h00, "rd3");
    check("rd3_const", data_out, 8'hA5);
    step(1'b0, 1'b0, 4'd12, 4'd0, 8'h00, "hold1");
    step(1'b0, 1'b0, 4'd7, 4'd0, 8'h00, "hold2");
    step(1'b0, 1'b0, 4'd0, 4'd0, 8'h00, "hold3");
    check("hold_const", data_out, 8'hA5);
    step(1'b1, 1'b0, 4'd12, 4'd0, 8'h00, "rd12");
    check("rd12_const", data_out, 8'h3C);

    step(1'b0, 1'b1, 4'd0, 4'd5, 8'h11, "wr5");
    step(1'b1, 1'b1, 4'd5, 4'd5, 8'h22, "rbw5");
    check("rbw5_const", data_out, 8'h11);
    step(1'b1, 1'b0, 4'd5, 4'd0, 8'h00, "rd5_new");
    check("rd5_new_const", data_out, 8'h22);
    step(1'b1, 1'b1, 4'd3, 4'd7, 8'h77, "rw_diff");
    check("rw_diff_const", data_out, 8'hA5);
    step(1'b1, 1'b0, 4'd7, 4'd0, 8'h00, "rd7");
    check("rd7_const", data_out, 8'h77);

    for (int i = 0; i < 10; i++) begin
      a = 4'($urandom_range(15));
      d = 8'($urandom);
      step(1'b0, 1'b1, 4'd0, a, d, "rand_wr");
    end
    for (int i = 0; i < 10; i++) begin
      a = 4'($urandom_range(15));
      step(1'b1, 1'b0, a, 4'd0, 8'h00, "rand_rd");
    end

    // Make data_out nonzero before the mid-operation reset.
    step(1'b0, 1'b1, 4'd0, 4'd9, 8'h5A, "wr9");
    step(1'b1, 1'b0, 4'd9, 4'd0, 8'h00, "rd9");
    check("rd9_const", data_out, 8'h5A);
    @(negedge clk);
    read = 1'b1; write = 1'b1;
    rd_addr = 4'd9; wr_addr = 4'd9; data_in = 8'hFF;
    #2;
    reset = 1'b1;
    #1;
    check("reset_async", data_out, 8'h00);
    @(posedge clk);
    #1;
    check("reset_hold", data_out, 8'h00);
    @(negedge clk);
    reset = 1'b0; read = 1'b0; write = 1'b0;
    clear_model();
    step(1'b1, 1'b0, 4'd9, 4'd0, 8'h00, "rd9_after_rst");
    check("rd9_after_rst_const", data_out, 8'h00);
    sweep_zero("mid_reset");

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
